// File: rtl/pwm_generator.sv
// -----------------------------------------------------------------------------
// pwm_generator
//   PWM output stage for the duty/period adjust path. Samples the debounced
//   Duty (percent) and Count_P (period in CLK cycles) settings, computes the
//   high-time threshold Count_P*Duty/DUTY_MAX with a sequential shift-add
//   multiplier followed by a restoring divider, and applies the new
//   period/threshold pair together at the next period boundary.
//
//   Ports:
//     CLK           system clock
//     Rstn          asynchronous active-low reset
//     Duty          requested duty in percent, clamped to DUTY_MAX
//     Count_P       requested period in CLK cycles, 0 stops the PWM
//     PWM_Out       registered PWM waveform
//     Period_Start  one-cycle pulse when PWM_Out reflects counter value 0
//     Update_Done   one-cycle pulse, aligned with Period_Start, when new
//                   settings take effect
//     PWM_N         (PWM_COMPL_EN only) complementary output with dead time
//
//   Build option:
//     PWM_COMPL_EN  adds the PWM_N output and the DEAD_CYC dead-time logic.
// -----------------------------------------------------------------------------
module pwm_generator #(
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned DUTY_MAX = 100
`ifdef PWM_COMPL_EN
    ,
    parameter int unsigned DEAD_CYC = 4
`endif
) (
    input  logic              CLK,
    input  logic              Rstn,
    input  logic [DUTY_W-1:0] Duty,
    input  logic [CNT_W-1:0]  Count_P,
    output logic              PWM_Out,
    output logic              Period_Start,
    output logic              Update_Done
`ifdef PWM_COMPL_EN
    ,
    output logic              PWM_N
`endif
);

    localparam int unsigned PROD_W    = CNT_W + DUTY_W;
    localparam int unsigned MUL_STEPS = DUTY_W;
    localparam int unsigned DIV_STEPS = PROD_W;
    localparam int unsigned STEP_W    = $clog2(PROD_W);
    // Remainder stays below DUTY_MAX; one extra bit holds the shifted-in value.
    localparam int unsigned REM_W     = $clog2(DUTY_MAX) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } calc_state_t;

    calc_state_t        state;
    logic [DUTY_W-1:0]  smp_D;
    logic [CNT_W-1:0]   smp_P;
    logic [STEP_W-1:0]  step;
    logic [PROD_W-1:0]  work;      // product during MUL, dividend/quotient during DIV
    logic [PROD_W-1:0]  mcand;
    logic [DUTY_W-1:0]  mplier;
    logic [REM_W-1:0]   rem;

    logic [CNT_W-1:0]   new_P;
    logic [CNT_W-1:0]   new_H;
    logic               pending;

    logic [CNT_W-1:0]   act_P;
    logic [CNT_W-1:0]   act_H;
    logic [CNT_W-1:0]   cnt;
    logic               upd_q;

    // Clamp and compare the live settings against the last sampled pair
    logic [DUTY_W-1:0]  duty_clamp_c;
    logic               settings_diff_c;

    assign duty_clamp_c    = (Duty > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : Duty;
    assign settings_diff_c = (duty_clamp_c != smp_D) || (Count_P != smp_P);

    // One shift-add step and one restoring-division step
    logic [PROD_W-1:0]  mul_sum_c;
    logic [REM_W-1:0]   rem_sh_c;
    logic               rem_ge_c;

    assign mul_sum_c = work + (mplier[0] ? mcand : '0);
    assign rem_sh_c  = {rem[REM_W-2:0], work[PROD_W-1]};
    assign rem_ge_c  = (rem_sh_c >= REM_W'(DUTY_MAX));

    // Result is only handed over if the inputs did not move during the calculation
    logic               done_load_c;

    assign done_load_c = (state == ST_DONE) && !settings_diff_c;

    // Period boundary: counter wraps, or PWM is stopped so updates apply at once
    logic               boundary_c;
    logic               pwm_nx_c;
    logic               start_nx_c;

    assign boundary_c = (act_P == '0) || (cnt == act_P - CNT_W'(1));
    assign pwm_nx_c   = (act_P != '0) && (cnt < act_H);
    assign start_nx_c = (act_P != '0) && (cnt == '0);

    // Threshold calculation FSM: IDLE -> MUL (8) -> DIV (32) -> DONE -> IDLE
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            state  <= ST_IDLE;
            smp_D  <= '0;
            smp_P  <= '0;
            step   <= '0;
            work   <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            new_P  <= '0;
            new_H  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (settings_diff_c) begin
                        smp_D  <= duty_clamp_c;
                        smp_P  <= Count_P;
                        work   <= '0;
                        mcand  <= PROD_W'(Count_P);
                        mplier <= duty_clamp_c;
                        rem    <= '0;
                        step   <= '0;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    work   <= mul_sum_c;
                    mcand  <= {mcand[PROD_W-2:0], 1'b0};
                    mplier <= {1'b0, mplier[DUTY_W-1:1]};
                    if (step == STEP_W'(MUL_STEPS - 1)) begin
                        step  <= '0;
                        state <= ST_DIV;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                ST_DIV: begin
                    rem  <= rem_ge_c ? (rem_sh_c - REM_W'(DUTY_MAX)) : rem_sh_c;
                    work <= {work[PROD_W-2:0], rem_ge_c};
                    if (step == STEP_W'(DIV_STEPS - 1)) begin
                        step  <= '0;
                        state <= ST_DONE;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                ST_DONE: begin
                    // Quotient never exceeds smp_P, so the low CNT_W bits hold it
                    if (!settings_diff_c) begin
                        new_P <= smp_P;
                        new_H <= work[CNT_W-1:0];
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Period counter, boundary update and registered outputs
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            cnt          <= '0;
            act_P        <= '0;
            act_H        <= '0;
            pending      <= 1'b0;
            upd_q        <= 1'b0;
            PWM_Out      <= 1'b0;
            Period_Start <= 1'b0;
            Update_Done  <= 1'b0;
        end else begin
            if (boundary_c) begin
                cnt <= '0;
                // act_P and act_H always move together
                if (pending) begin
                    act_P <= new_P;
                    act_H <= new_H;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // A fresh result wins over clearing; it is applied at the next boundary
            pending      <= done_load_c || (pending && !boundary_c);
            upd_q        <= boundary_c && pending;
            Update_Done  <= upd_q;
            PWM_Out      <= pwm_nx_c;
            Period_Start <= start_nx_c;
        end
    end

`ifdef PWM_COMPL_EN
    localparam int unsigned DEAD_W = (DEAD_CYC < 1) ? 1 : $clog2(DEAD_CYC + 1);

    // Cycles PWM_Out has held its current level, saturating at DEAD_CYC
    logic [DEAD_W-1:0] hold_cnt;
    logic [DEAD_W-1:0] hold_nx_c;

    assign hold_nx_c = (pwm_nx_c != PWM_Out)               ? '0 :
                       (hold_cnt == DEAD_W'(DEAD_CYC))      ? hold_cnt :
                                                              hold_cnt + DEAD_W'(1);

    // PWM_N rises only once the low phase has lasted DEAD_CYC cycles
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            hold_cnt <= '0;
            PWM_N    <= 1'b0;
        end else begin
            hold_cnt <= hold_nx_c;
            PWM_N    <= (act_P != '0) && !pwm_nx_c && (hold_nx_c == DEAD_W'(DEAD_CYC));
        end
    end
`endif

endmodule
